// File: rtl/uart_tx_unit.sv
// UART transmitter: start, 8 data bits LSB first, parity, stop; own baud counter.
// Define UART_TX_HOLD_REG_EN to add a one-entry holding register for back-to-back frames.
module uart_tx_unit #(
  parameter int CLK_FREQ = 192000
) (
  input  logic       clock,
  input  logic       rst,
  input  logic [1:0] baudRate,
  input  logic       pType,
  input  logic [7:0] dataIn,
  input  logic       txValid,
  output logic       txReady,
  output logic       serialOutput,
  output logic       busy,
  output logic       done
);

  localparam int DIV0 = CLK_FREQ / 2400;
  localparam int CW   = $clog2(DIV0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rld_q, rld_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    bit_nx;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic          txd_q, txd_d;

  logic          fire;
  logic          tick;
  logic          last;
  logic          ld;
  logic [7:0]    ld_data;
  logic [1:0]    ld_baud;
  logic          ld_pt;

  // Reload value is DIV-1 so the counter spends exactly DIV clocks per bit.
  function automatic logic [CW-1:0] rld_of(input logic [1:0] b);
    return CW'((DIV0 >> b) - 1);
  endfunction

  assign fire         = txValid && txReady;
  assign tick         = (cnt_q == '0);
  assign last         = (state_q == STOP) && tick;
  assign done         = last;
  assign busy         = (state_q != IDLE);
  assign serialOutput = txd_q;
  assign bit_nx       = bit_q + 3'd1;

`ifdef UART_TX_HOLD_REG_EN
  logic       hfull_q, hfull_d;
  logic [7:0] hdata_q, hdata_d;
  logic [1:0] hbaud_q, hbaud_d;
  logic       hpt_q, hpt_d;

  assign txReady = !hfull_q;

  always_comb begin
    hfull_d = hfull_q;
    hdata_d = hdata_q;
    hbaud_d = hbaud_q;
    hpt_d   = hpt_q;
    ld      = 1'b0;
    ld_data = dataIn;
    ld_baud = baudRate;
    ld_pt   = pType;
    if (state_q == IDLE) begin
      ld = fire;
    end else if (last && hfull_q) begin
      ld      = 1'b1;
      ld_data = hdata_q;
      ld_baud = hbaud_q;
      ld_pt   = hpt_q;
      hfull_d = 1'b0;
    end else if (last) begin
      ld = fire;
    end else if (fire) begin
      hfull_d = 1'b1;
      hdata_d = dataIn;
      hbaud_d = baudRate;
      hpt_d   = pType;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      hfull_q <= 1'b0;
      hdata_q <= '0;
      hbaud_q <= '0;
      hpt_q   <= 1'b0;
    end else begin
      hfull_q <= hfull_d;
      hdata_q <= hdata_d;
      hbaud_q <= hbaud_d;
      hpt_q   <= hpt_d;
    end
  end
`else
  assign txReady = (state_q == IDLE);

  always_comb begin
    ld      = fire;
    ld_data = dataIn;
    ld_baud = baudRate;
    ld_pt   = pType;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    bit_d   = bit_q;
    data_d  = data_q;
    par_d   = par_q;
    txd_d   = txd_q;

    if (state_q != IDLE) begin
      cnt_d = tick ? rld_q : cnt_q - CW'(1);
    end

    unique case (state_q)
      IDLE: begin
        txd_d = 1'b1;
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = 3'd0;
          txd_d   = data_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
            state_d = PARITY;
            txd_d   = par_q;
          end else begin
            bit_d = bit_nx;
            txd_d = data_q[bit_nx];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          txd_d   = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          txd_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // A new frame latches its own rate and parity type; later input changes are ignored.
    if (ld) begin
      state_d = START;
      txd_d   = 1'b0;
      cnt_d   = rld_of(ld_baud);
      rld_d   = rld_of(ld_baud);
      data_d  = ld_data;
      par_d   = (^ld_data) ^ ld_pt;
      bit_d   = 3'd0;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rld_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_unit.sv
// Scoreboard bench for uart_tx_unit: accepted bytes are queued, the line monitor
// decodes each frame clock by clock and compares it against the queued byte.
module tb_uart_tx_unit;

  localparam int CLK_FREQ = 192000;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] baudRate = 2'b00;
  logic       pType = 1'b0;
  logic [7:0] dataIn = 8'h00;
  logic       txValid = 1'b0;
  logic       txReady;
  logic       serialOutput;
  logic       busy;
  logic       done;

  uart_tx_unit #(.CLK_FREQ(CLK_FREQ)) dut (
    .clock       (clock),
    .rst         (rst),
    .baudRate    (baudRate),
    .pType       (pType),
    .dataIn      (dataIn),
    .txValid     (txValid),
    .txReady     (txReady),
    .serialOutput(serialOutput),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] d;
    logic [1:0] b;
    logic       p;
  } exp_t;

  exp_t q[$];
  int   done_q[$];
  int   nchecks = 0;
  int   nfail = 0;
  int   frames_done = 0;
  int   ncyc = 0;
  int   last_done = -1000;
  int   last_gap = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    if (!rst && txValid && txReady) begin
      q.push_back('{d: dataIn, b: baudRate, p: pType});
    end
  end

  initial begin : mon
    exp_t e;
    logic bits[11];
    logic exp_rdy;
    int   div, eb, ed, ebz, er;
    bit   abort, ended;
    ended = 1'b0;
    forever begin
      @(negedge clock);
      ncyc++;
      if (rst) begin
        q.delete();
        ended = 1'b0;
        last_done = -1000;
        continue;
      end
      if (ended) begin
        chk("rdy_after", {31'd0, txReady}, 1);
        ended = 1'b0;
      end
      if (serialOutput) begin
        chk("idle_busy", {31'd0, busy}, 0);
        chk("idle_done", {31'd0, done}, 0);
        continue;
      end
      last_gap = ncyc - last_done;
`ifndef UART_TX_HOLD_REG_EN
      chk("gap_ge2", {31'd0, last_gap >= 2}, 1);
`endif
      if (q.size() == 0) begin
        chk("sb_empty", 0, 1);
        continue;
      end
      e = q.pop_front();
      div = CLK_FREQ / (2400 << e.b);
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = e.d[i];
      bits[9] = (($countones(e.d) % 2) == 1) ^ e.p;
      bits[10] = 1'b1;
      eb = 0; ed = 0; ebz = 0; er = 0; abort = 1'b0;
      for (int k = 1; k <= 11 * div; k++) begin
        if (k > 1) begin
          @(negedge clock);
          ncyc++;
          if (rst) begin
            abort = 1'b1;
            break;
          end
        end
`ifdef UART_TX_HOLD_REG_EN
        exp_rdy = (q.size() == 0);
`else
        exp_rdy = 1'b0;
`endif
        if (serialOutput !== bits[(k-1)/div]) eb++;
        if (done !== (k == 11 * div)) ed++;
        if (busy !== 1'b1) ebz++;
        if (txReady !== exp_rdy) er++;
        if (done) last_done = ncyc;
      end
      chk("bits", eb, 0);
      chk("done_pos", ed, 0);
      chk("busy_frame", ebz, 0);
      chk("rdy_frame", er, 0);
      if (abort) begin
        q.delete();
        last_done = -1000;
      end else begin
        frames_done++;
        done_q.push_back(last_done);
        ended = 1'b1;
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [1:0] b, input logic p);
    int t;
    @(negedge clock);
    dataIn = d;
    baudRate = b;
    pType = p;
    txValid = 1'b1;
    t = 0;
    while (!txReady && t < 5000) begin
      @(negedge clock);
      t++;
    end
    chk("send_timeout", {31'd0, txReady}, 1);
    @(posedge clock);
    #1 txValid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (frames_done < n && t < 20000) begin
      @(negedge clock);
      t++;
    end
    chk("frame_timeout", {31'd0, frames_done >= n}, 1);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("rst_line", {31'd0, serialOutput}, 1);
      chk("rst_rdy", {31'd0, txReady}, 1);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
    end

    send(8'hA5, 2'b10, 1'b0);
    repeat (30) @(negedge clock);
    send(8'hFF, 2'b11, 1'b1);
    wait_frames(2);

    send(8'h00, 2'b11, 1'b1);
    wait_frames(3);

    send(8'h3C, 2'b10, 1'b0);
    repeat (50) @(negedge clock);
    chk("pre_rst_line", {31'd0, serialOutput}, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_line", {31'd0, serialOutput}, 1);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_done", {31'd0, done}, 0);
    chk("arst_rdy", {31'd0, txReady}, 1);
    repeat (3) @(negedge clock);
    rst = 1'b0;
    chk("rst_frames", frames_done, 3);
    send(8'h3C, 2'b00, 1'b0);
    wait_frames(4);

`ifdef UART_TX_HOLD_REG_EN
    send(8'h11, 2'b11, 1'b0);
    send(8'h22, 2'b11, 1'b0);
    wait_frames(6);
    chk("b2b_gap", last_gap, 1);
    chk("done_space", done_q[$] - done_q[$-1], 110);
`endif

    repeat (5) @(negedge clock);
    chk("sb_drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
